usb_ep_buf: RTL and testbench
=============================

# usb_ep_buf

Device-side endpoint buffer for the USB 3.1 ULPI device path, sitting between the protocol engine and the user buffer port. It owns one 512-byte IN buffer and one 512-byte OUT buffer. The user side writes IN bytes and commits them; the block streams committed bytes to the packet transmitter. It captures received packets into the OUT buffer and presents them through the `buf_out_*` read/arm handshake.

## Interface
- `MAX_PKT`, 512, buffer depth in bytes; address width 9, length width 10.
- `phy_ulpi_clk  in  1  sole clock, all logic on posedge`
- `reset  in  1  asynchronous, active-high reset`
- `buf_in_addr  in  9  IN buffer write address`
- `buf_in_data  in  8  IN write byte`
- `buf_in_wren  in  1  IN write strobe, honoured only while buf_in_ready=1`
- `buf_in_ready  out  1  IN buffer accepting writes/commit`
- `buf_in_commit  in  1  commit pulse`
- `buf_in_commit_len  in  10  committed length, clamped to 512`
- `buf_in_commit_ack  out  1  one-cycle pulse: packet fully sent`
- `buf_out_addr  in  9  OUT read address`
- `buf_out_q  out  8  OUT read data, 1-cycle latency`
- `buf_out_len  out  10  received packet length`
- `buf_out_hasdata  out  1  OUT buffer holds a packet`
- `buf_out_arm  in  1  release OUT buffer pulse`
- `buf_out_arm_ack  out  1  one-cycle arm acknowledge`
- `tx_valid / tx_data[7:0] / tx_last / tx_zlp  out  transmit stream; tx_ready in`
- `rx_valid / rx_data[7:0] / rx_eop / rx_err  in  receive stream`
- `err_pkt_drop  out  1  one-cycle pulse on discarded rx packet`

## Operation
- Reset: buf_in_ready=1, all other outputs 0, IN FSM IN_IDLE, OUT FSM OUT_ARMED, rx count 0.
- IN FSM IN_IDLE -> IN_SEND -> IN_ACK -> IN_IDLE.
  - IN_IDLE: wren writes RAM[addr]. commit latches L=min(commit_len,512) and enters IN_SEND. wren and commit in the same cycle: write completes and the byte is included.
  - IN_SEND: buf_in_ready=0. Writes and commits are ignored. Bytes 0..L-1 are presented in order; a beat transfers when tx_valid&&tx_ready; tx_last=1 on byte L-1. tx_valid/tx_data hold stable until accepted.
  - L=0: one beat with tx_last=1, tx_zlp=1, tx_data=0.
  - Final beat accepted -> IN_ACK. IN_ACK lasts one cycle: commit_ack=1 and ready=1 in that same cycle. Next cycle IN_IDLE.
- OUT FSM OUT_ARMED <-> OUT_FULL.
  - OUT_ARMED: each rx_valid writes RAM[count], count++. rx_eop sets buf_out_len=count and hasdata=1 and moves to OUT_FULL; count is cleared. rx_eop with count 0 gives len=0.
  - A 513th byte is an overflow.
  - OUT_FULL: rx traffic ignored (dropped silently). buf_out_arm clears hasdata and len the next cycle, pulses arm_ack, and returns to OUT_ARMED.
  - arm in OUT_ARMED: arm_ack still pulses, count reset to 0 (partial packet discarded).
- buf_out_q = RAM[buf_out_addr] registered every cycle regardless of state.

## Timing
- commit at cycle T: ready=0 at T+1; first tx_valid at T+2 (one cycle RAM read plus output register). The next byte is prefetched, so back-to-back tx_ready gives 1 byte/cycle.
- Last beat accepted at cycle S: commit_ack=1 and ready=1 at S+1.
- rx_eop at cycle R: hasdata=1 and len valid at R+1.
- arm at cycle A: arm_ack=1 and hasdata=0 at A+1.
- buf_out_q is valid one cycle after buf_out_addr.
- Async reset mid-packet: outputs and FSMs return to reset values immediately. The RAM contents are undefined and are not relied on.

## Configuration
- `USB_EPBUF_RX_DROP_EN` defined:
  - A packet with rx_err=1 on any beat or on rx_eop is discarded, as is an overflowing packet.
  - On discard: state stays OUT_ARMED, count clears at rx_eop, err_pkt_drop pulses at R+1, hasdata stays 0.
- Undefined:
  - rx_err is ignored.
  - Overflow bytes are discarded; the packet completes with len=512.
  - err_pkt_drop is tied 0.

## Test plan
- Write bytes 0x00..0x3F to addr 0..63, commit len 64, tx_ready=1 -> 64 beats data 0x00..0x3F, tx_last on beat 63, commit_ack at S+1, ready=1.
- Commit len 0 -> single beat, tx_zlp=1, tx_last=1; commit_len 600 -> 512 beats. Writes during IN_SEND do not alter the transmitted data.
- rx 10 bytes 0xA0..0xA9 plus rx_eop -> hasdata=1, len=10. Reading addr 3 returns 0xA3 one cycle later. Arm -> arm_ack pulse, hasdata=0. A second packet while OUT_FULL is ignored.
- rx 513 bytes plus eop: with the macro defined -> err_pkt_drop pulse, hasdata=0; without -> len=512.
- rx_err on byte 2 of 5: with the macro -> drop pulse and the buffer stays armed; the next clean 4-byte packet reports len=4.
- Assert reset during IN_SEND beat 5 -> tx_valid=0 and ready=1 immediately; a fresh commit after release transmits correctly.

Source files
------------

// File: rtl/usb_ep_buf.sv
// usb_ep_buf: device-side USB endpoint buffer with one 512-byte IN buffer
// (user writes, committed bytes streamed to the transmitter) and one 512-byte
// OUT buffer (received packet captured, read back by the user, then re-armed).
// Optional build macro: USB_EPBUF_RX_DROP_EN discards rx packets flagged with
// rx_err or overflowing the buffer, and reports them on err_pkt_drop.
module usb_ep_buf (
  input  logic       phy_ulpi_clk,
  input  logic       reset,
  // user IN side
  input  logic [8:0] buf_in_addr,
  input  logic [7:0] buf_in_data,
  input  logic       buf_in_wren,
  output logic       buf_in_ready,
  input  logic       buf_in_commit,
  input  logic [9:0] buf_in_commit_len,
  output logic       buf_in_commit_ack,
  // user OUT side
  input  logic [8:0] buf_out_addr,
  output logic [7:0] buf_out_q,
  output logic [9:0] buf_out_len,
  output logic       buf_out_hasdata,
  input  logic       buf_out_arm,
  output logic       buf_out_arm_ack,
  // transmit stream
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic       tx_zlp,
  input  logic       tx_ready,
  // receive stream
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_eop,
  input  logic       rx_err,
  output logic       err_pkt_drop
);

  localparam int unsigned MAX_PKT = 512;
  localparam int unsigned AW      = 9;
  localparam int unsigned LW      = 10;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT);
  localparam logic [LW-1:0] ONE     = LW'(1);

  typedef enum logic [1:0] {IN_IDLE, IN_SEND, IN_ACK} in_state_e;
  typedef enum logic {OUT_ARMED, OUT_FULL} out_state_e;

  logic [7:0] in_mem  [MAX_PKT];
  logic [7:0] out_mem [MAX_PKT];

  // IN path
  in_state_e     in_state_q, in_state_d;
  logic [LW-1:0] in_len_q, in_len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    in_rd_q, in_rd_d;
  logic          in_we;
  logic          last_beat;

  // OUT path
  out_state_e    out_state_q, out_state_d;
  logic [LW-1:0] rx_cnt_q, rx_cnt_d;
  logic [LW-1:0] out_len_q, out_len_d;
  logic          arm_ack_q, arm_ack_d;
  logic [7:0]    out_q_q, out_q_d;
  logic          out_we;
`ifdef USB_EPBUF_RX_DROP_EN
  logic          bad_q, bad_d;
  logic          drop_q, drop_d;
`endif

  // beat_q indexes the byte currently presented; length 0 is a single ZLP beat
  assign last_beat = (in_len_q == '0) || (beat_q == in_len_q - ONE);

  // IN FSM: accept writes/commit, then stream bytes 0..L-1 with backpressure.
  // The read register is loaded from the address of the byte to present next
  // cycle, so an accepted beat is immediately followed by the prefetched one.
  always_comb begin
    in_state_d = in_state_q;
    in_len_d   = in_len_q;
    beat_d     = beat_q;
    tx_valid_d = tx_valid_q;
    in_we      = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        in_we = buf_in_wren;
        if (buf_in_commit) begin
          in_len_d   = (buf_in_commit_len > MAX_LEN) ? MAX_LEN : buf_in_commit_len;
          beat_d     = '0;
          tx_valid_d = 1'b0;
          in_state_d = IN_SEND;
        end
      end
      IN_SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          if (last_beat) begin
            tx_valid_d = 1'b0;
            in_state_d = IN_ACK;
          end else begin
            beat_d = beat_q + ONE;
          end
        end
      end
      IN_ACK: begin
        in_we      = buf_in_wren;
        in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase
    in_rd_d = in_mem[beat_d[AW-1:0]];
  end

  assign buf_in_ready      = (in_state_q != IN_SEND);
  assign buf_in_commit_ack = (in_state_q == IN_ACK);
  assign tx_valid          = tx_valid_q;
  assign tx_last           = tx_valid_q && last_beat;
  assign tx_zlp            = tx_valid_q && (in_len_q == '0);
  assign tx_data           = (tx_valid_q && (in_len_q != '0)) ? in_rd_q : '0;

  // OUT FSM: capture rx bytes while armed, publish length on eop, release on arm
  always_comb begin
    out_state_d = out_state_q;
    rx_cnt_d    = rx_cnt_q;
    out_len_d   = out_len_q;
    arm_ack_d   = 1'b0;
    out_we      = 1'b0;
`ifdef USB_EPBUF_RX_DROP_EN
    bad_d       = bad_q;
    drop_d      = 1'b0;
`endif
    case (out_state_q)
      OUT_ARMED: begin
        if (buf_out_arm) begin
          // re-arming while armed throws away any partial packet
          arm_ack_d = 1'b1;
          rx_cnt_d  = '0;
`ifdef USB_EPBUF_RX_DROP_EN
          bad_d     = 1'b0;
`endif
        end else begin
          if (rx_valid) begin
            if (rx_cnt_q < MAX_LEN) begin
              out_we   = 1'b1;
              rx_cnt_d = rx_cnt_q + ONE;
            end
`ifdef USB_EPBUF_RX_DROP_EN
            else begin
              bad_d = 1'b1;
            end
`endif
          end
`ifdef USB_EPBUF_RX_DROP_EN
          if ((rx_valid || rx_eop) && rx_err) begin
            bad_d = 1'b1;
          end
`endif
          if (rx_eop) begin
`ifdef USB_EPBUF_RX_DROP_EN
            if (bad_d) begin
              drop_d = 1'b1;
            end else begin
              out_len_d   = rx_cnt_d;
              out_state_d = OUT_FULL;
            end
            bad_d = 1'b0;
`else
            out_len_d   = rx_cnt_d;
            out_state_d = OUT_FULL;
`endif
            rx_cnt_d = '0;
          end
        end
      end
      OUT_FULL: begin
        if (buf_out_arm) begin
          arm_ack_d   = 1'b1;
          out_len_d   = '0;
          rx_cnt_d    = '0;
          out_state_d = OUT_ARMED;
        end
      end
      default: out_state_d = OUT_ARMED;
    endcase
    out_q_d = out_mem[buf_out_addr];
  end

  assign buf_out_hasdata = (out_state_q == OUT_FULL);
  assign buf_out_len     = out_len_q;
  assign buf_out_arm_ack = arm_ack_q;
  assign buf_out_q       = out_q_q;
`ifdef USB_EPBUF_RX_DROP_EN
  assign err_pkt_drop    = drop_q;
`else
  logic unused_rx_err;
  assign unused_rx_err   = rx_err;
  assign err_pkt_drop    = 1'b0;
`endif

  // Buffer storage: no reset, contents undefined after reset
  always_ff @(posedge phy_ulpi_clk) begin
    if (in_we) begin
      in_mem[buf_in_addr] <= buf_in_data;
    end
    if (out_we) begin
      out_mem[rx_cnt_q[AW-1:0]] <= rx_data;
    end
  end

  // State and output registers
  always_ff @(posedge phy_ulpi_clk or posedge reset) begin
    if (reset) begin
      in_state_q  <= IN_IDLE;
      in_len_q    <= '0;
      beat_q      <= '0;
      tx_valid_q  <= 1'b0;
      in_rd_q     <= '0;
      out_state_q <= OUT_ARMED;
      rx_cnt_q    <= '0;
      out_len_q   <= '0;
      arm_ack_q   <= 1'b0;
      out_q_q     <= '0;
`ifdef USB_EPBUF_RX_DROP_EN
      bad_q       <= 1'b0;
      drop_q      <= 1'b0;
`endif
    end else begin
      in_state_q  <= in_state_d;
      in_len_q    <= in_len_d;
      beat_q      <= beat_d;
      tx_valid_q  <= tx_valid_d;
      in_rd_q     <= in_rd_d;
      out_state_q <= out_state_d;
      rx_cnt_q    <= rx_cnt_d;
      out_len_q   <= out_len_d;
      arm_ack_q   <= arm_ack_d;
      out_q_q     <= out_q_d;
`ifdef USB_EPBUF_RX_DROP_EN
      bad_q       <= bad_d;
      drop_q      <= drop_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_ep_buf.sv
// tb_usb_ep_buf: scoreboard bench for usb_ep_buf. Stimulus tasks push the
// expected responses into queues/counters; a negedge monitor pops and compares
// whenever the DUT presents a beat, pulse, length or read word.
module tb_usb_ep_buf;

  logic       phy_ulpi_clk = 1'b0;
  logic       reset;
  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic       buf_in_wren;
  logic       buf_in_ready;
  logic       buf_in_commit;
  logic [9:0] buf_in_commit_len;
  logic       buf_in_commit_ack;
  logic [8:0] buf_out_addr;
  logic [7:0] buf_out_q;
  logic [9:0] buf_out_len;
  logic       buf_out_hasdata;
  logic       buf_out_arm;
  logic       buf_out_arm_ack;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_zlp;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_eop;
  logic       rx_err;
  logic       err_pkt_drop;

  usb_ep_buf dut (
    .phy_ulpi_clk      (phy_ulpi_clk),
    .reset             (reset),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .buf_out_addr      (buf_out_addr),
    .buf_out_q         (buf_out_q),
    .buf_out_len       (buf_out_len),
    .buf_out_hasdata   (buf_out_hasdata),
    .buf_out_arm       (buf_out_arm),
    .buf_out_arm_ack   (buf_out_arm_ack),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_last           (tx_last),
    .tx_zlp            (tx_zlp),
    .tx_ready          (tx_ready),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .rx_eop            (rx_eop),
    .rx_err            (rx_err),
    .err_pkt_drop      (err_pkt_drop)
  );

  always #5 phy_ulpi_clk = ~phy_ulpi_clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       zlp;
  } beat_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // scoreboard
  beat_t       tx_exp[$];
  logic [9:0]  len_exp[$];
  logic [7:0]  rd_exp[$];
  int unsigned arm_exp   = 0;
  int unsigned drop_exp  = 0;
  int unsigned acks_seen = 0;
  int unsigned beats_seen = 0;
  bit          ack_due = 1'b0;
  bit          hasdata_prev = 1'b0;
  bit          rd_req = 1'b0;
  bit          rd_req_d1 = 1'b0;
  bit          rdy_random = 1'b0;

  // reference model state
  logic [7:0]  m_in  [512];
  logic [7:0]  m_out [512];
  logic [7:0]  m_rx[$];
  bit          m_full = 1'b0;
  bit          m_bad  = 1'b0;
  bit          m_ovf  = 1'b0;
  int unsigned m_len  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void note_fail(input string name, input logic [31:0] act);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
  endfunction

  task automatic tick();
    @(posedge phy_ulpi_clk);
    #1;
  endtask

  always @(posedge phy_ulpi_clk) rd_req_d1 <= rd_req;

  // transmitter backpressure
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge phy_ulpi_clk);
      #1;
      tx_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // monitor: compares DUT outputs against the scoreboard
  always @(negedge phy_ulpi_clk) begin
    if (reset) begin
      ack_due      = 1'b0;
      hasdata_prev = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        beats_seen++;
        if (tx_exp.size() == 0) note_fail("tx_beat_unexpected", {tx_data, tx_last, tx_zlp});
        else check("tx_beat", {tx_data, tx_last, tx_zlp}, tx_exp.pop_front());
      end
      if (buf_in_commit_ack || ack_due) begin
        check("commit_ack_S1", buf_in_commit_ack, ack_due);
        if (buf_in_commit_ack) begin
          check("ready_at_ack", buf_in_ready, 1);
          acks_seen++;
        end
      end
      ack_due = tx_valid && tx_ready && tx_last;
      if (buf_out_hasdata && !hasdata_prev) begin
        if (len_exp.size() == 0) note_fail("out_len_unexpected", buf_out_len);
        else check("out_len", buf_out_len, len_exp.pop_front());
      end
      hasdata_prev = buf_out_hasdata;
      if (buf_out_arm_ack) begin
        check("arm_ack_expected", arm_exp != 0, 1);
        if (arm_exp != 0) arm_exp--;
      end
      if (err_pkt_drop) begin
        check("drop_expected", drop_exp != 0, 1);
        if (drop_exp != 0) drop_exp--;
      end
      if (rd_req_d1) begin
        if (rd_exp.size() == 0) note_fail("buf_out_q_unexpected", buf_out_q);
        else check("buf_out_q", buf_out_q, rd_exp.pop_front());
      end
    end
  end

  task automatic in_write(input logic [8:0] a, input logic [7:0] d);
    buf_in_addr = a;
    buf_in_data = d;
    buf_in_wren = 1'b1;
    m_in[a]     = d;
    tick();
    buf_in_wren = 1'b0;
  endtask

  task automatic in_commit(input int unsigned len, input bit scribble, input bit wait_done);
    int unsigned l;
    int unsigned guard;
    int unsigned acks0;
    l = (len > 512) ? 512 : len;
    if (l == 0) tx_exp.push_back({8'h00, 1'b1, 1'b1});
    else for (int unsigned i = 0; i < l; i++) tx_exp.push_back({m_in[i], (i == l - 1), 1'b0});
    acks0 = acks_seen;
    buf_in_commit     = 1'b1;
    buf_in_commit_len = len[9:0];
    tick();
    buf_in_commit = 1'b0;
    buf_in_wren   = 1'b0;
    check("ready_low_T1", buf_in_ready, 0);
    check("tx_valid_T1", tx_valid, 0);
    tick();
    check("tx_valid_T2", tx_valid, 1);
    if (wait_done) begin
      guard = 0;
      while (acks_seen == acks0 && guard < 3000) begin
        if (scribble) begin
          // writes while sending must not reach the transmitted data
          buf_in_wren = !buf_in_ready && ($urandom_range(0, 1) == 1);
          buf_in_addr = 9'($urandom_range(0, 511));
          buf_in_data = 8'($urandom_range(0, 255));
        end
        tick();
        guard++;
      end
      buf_in_wren = 1'b0;
      check("tx_done_in_time", guard < 3000, 1);
      tick();
    end
  endtask

  task automatic rx_byte(input logic [7:0] d, input bit err);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_err   = err;
    if (!m_full) begin
      if (m_rx.size() < 512) m_rx.push_back(d);
      else m_ovf = 1'b1;
      if (err) m_bad = 1'b1;
    end
    tick();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic rx_end(input bit err);
    bit drop;
    drop   = 1'b0;
    rx_eop = 1'b1;
    rx_err = err;
    if (!m_full) begin
`ifdef USB_EPBUF_RX_DROP_EN
      drop = m_bad || m_ovf || err;
`endif
      if (drop) begin
        drop_exp++;
      end else begin
        m_full = 1'b1;
        m_len  = m_rx.size();
        foreach (m_rx[i]) m_out[i] = m_rx[i];
        len_exp.push_back(m_len[9:0]);
      end
      m_rx.delete();
      m_bad = 1'b0;
      m_ovf = 1'b0;
    end
    tick();
    rx_eop = 1'b0;
    rx_err = 1'b0;
    check("hasdata_R1", buf_out_hasdata, m_full);
    check("len_R1", buf_out_len, m_full ? m_len : 0);
    check("drop_R1", err_pkt_drop, drop);
  endtask

  task automatic rx_pkt(input int unsigned n, input logic [7:0] base, input int err_at);
    for (int unsigned i = 0; i < n; i++) rx_byte(base + i[7:0], int'(i) == err_at);
    rx_end(1'b0);
  endtask

  task automatic arm();
    buf_out_arm = 1'b1;
    arm_exp++;
    m_full = 1'b0;
    m_len  = 0;
    m_rx.delete();
    m_bad  = 1'b0;
    m_ovf  = 1'b0;
    tick();
    buf_out_arm = 1'b0;
    check("arm_ack_A1", buf_out_arm_ack, 1);
    check("hasdata_A1", buf_out_hasdata, 0);
    check("len_A1", buf_out_len, 0);
  endtask

  task automatic rd(input logic [8:0] a);
    buf_out_addr = a;
    rd_req       = 1'b1;
    rd_exp.push_back(m_out[a]);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, buf_in_ready, 1);
    check({tag, "_tx"}, {tx_valid, tx_data, tx_last, tx_zlp}, 0);
    check({tag, "_acks"}, {buf_in_commit_ack, buf_out_arm_ack, err_pkt_drop}, 0);
    check({tag, "_out"}, {buf_out_hasdata, buf_out_len}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time %0t reached the 900000 limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned start;
    int unsigned guard;
    int unsigned n;
    reset = 1'b1;
    buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 1'b0;
    buf_in_commit = 1'b0; buf_in_commit_len = '0;
    buf_out_addr = '0; buf_out_arm = 1'b0;
    rx_valid = 1'b0; rx_data = '0; rx_eop = 1'b0; rx_err = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    check("rst_buf_out_q", buf_out_q, 0);
    #2 reset = 1'b0;
    tick();
    check_reset_outputs("post_rst");

    // 64-byte packet; the last byte is written in the commit cycle
    rdy_random = 1'b0;
    for (int unsigned i = 0; i < 63; i++) in_write(i[8:0], i[7:0]);
    buf_in_addr = 9'd63; buf_in_data = 8'h3F; buf_in_wren = 1'b1; m_in[63] = 8'h3F;
    in_commit(64, 1'b0, 1'b1);
    check("ready_after_pkt", buf_in_ready, 1);

    // zero-length packet
    in_commit(0, 1'b0, 1'b1);

    // oversize commit clamps to 512, random backpressure, writes while sending
    rdy_random = 1'b1;
    for (int unsigned i = 0; i < 512; i++) in_write(i[8:0], 8'($urandom_range(0, 255)));
    in_commit(600, 1'b1, 1'b1);

    // randomized IN packets
    for (int unsigned k = 0; k < 5; k++) begin
      n = $urandom_range(0, 600);
      for (int unsigned i = 0; i < ((n > 512) ? 512 : n); i++)
        if ($urandom_range(0, 1) == 1) in_write(i[8:0], 8'($urandom_range(0, 255)));
      in_commit(n, 1'b1, 1'b1);
    end

    // OUT: 10-byte packet, readback, packet while full ignored, arm
    rx_pkt(10, 8'hA0, -1);
    rd(9'd3);
    rd(9'd0);
    rd(9'd9);
    rx_pkt(4, 8'h55, -1);
    rd(9'd3);
    arm();

    // 513-byte packet (overflow)
    for (int unsigned i = 0; i < 513; i++) rx_byte(8'($urandom_range(0, 255)), 1'b0);
    rx_end(1'b0);
    if (m_full) begin
      rd(9'd511);
      rd(9'd256);
      arm();
    end

    // rx_err on byte 2 of 5, then a clean 4-byte packet
    rx_pkt(5, 8'h10, 2);
    if (m_full) arm();
    rx_pkt(4, 8'h20, -1);
    rd(9'd1);
    arm();

    // arm while armed discards the partial packet
    rx_byte(8'hE0, 1'b0);
    rx_byte(8'hE1, 1'b0);
    rx_byte(8'hE2, 1'b0);
    arm();
    rx_pkt(2, 8'hC0, -1);
    rd(9'd0);
    rd(9'd1);
    arm();

    // eop with no bytes
    rx_end(1'b0);
    arm();

    // randomized OUT packets, error flagged on eop sometimes
    for (int unsigned k = 0; k < 8; k++) begin
      n = $urandom_range(0, 40);
      for (int unsigned i = 0; i < n; i++)
        rx_byte(8'($urandom_range(0, 255)), $urandom_range(0, 30) == 0);
      rx_end($urandom_range(0, 5) == 0);
      if (m_full) begin
        if (n > 0) rd(9'($urandom_range(0, n - 1)));
        if ($urandom_range(0, 1) == 1) begin
          rx_byte(8'hFF, 1'b0);
          rx_end(1'b0);
        end
        arm();
      end
    end

    // asynchronous reset in the middle of a transmit
    rdy_random = 1'b0;
    start = beats_seen;
    in_commit(64, 1'b0, 1'b0);
    guard = 0;
    while (beats_seen < start + 5 && guard < 100) begin
      @(negedge phy_ulpi_clk);
      guard++;
    end
    check("beats_before_reset", beats_seen >= start + 5, 1);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("midpkt_rst");
    tx_exp.delete();
    m_full = 1'b0; m_len = 0; m_rx.delete(); m_bad = 1'b0; m_ovf = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    check_reset_outputs("after_midpkt_rst");
    for (int unsigned i = 0; i < 20; i++) in_write(i[8:0], 8'(8'h80 + i));
    in_commit(20, 1'b0, 1'b1);

    repeat (3) tick();
    check("tx_queue_empty", tx_exp.size(), 0);
    check("len_queue_empty", len_exp.size(), 0);
    check("rd_queue_empty", rd_exp.size(), 0);
    check("arm_pending", arm_exp, 0);
    check("drop_pending", drop_exp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
